// File: rtl/dram_lsu_master.sv
// dram_lsu_master: turns MEM-stage load/store requests into DRAM driver bus
// transactions, splitting misaligned half/word accesses into byte beats.
module dram_lsu_master #(
  parameter int ADDR_W         = 18,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] perip_addr,
  output logic [31:0]       perip_wdata,
  output logic [1:0]        perip_mask,
  output logic              dram_wen,
  input  logic [31:0]       perip_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, BYTE, RESP} state_t;

  state_t            state, state_next;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [1:0]        idx_q;
  logic [1:0]        last_q;
  logic [31:0]       data_q;

  logic              accept;
  logic              f3_valid;
  logic              aligned;
  logic              err_d;
  logic [31:0]       store_lane;
  logic [31:0]       load_ext;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];
  assign req_ready      = (state == IDLE) || (state == RESP);
  assign accept         = req_valid && req_ready;

  // Loads allow b/h/w/bu/hu; stores only b/h/w.
  assign f3_valid = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                           : ((req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]));
  assign aligned  = req_funct3[1] ? (req_addr[1:0] == 2'b00)
                                  : (!req_funct3[0] || !req_addr[0]);
  assign err_d    = !f3_valid || (!aligned && !MISALIGN_SPLIT);

  always_comb begin
    store_lane = wdata_q;
    case (funct3_q[1:0])
      2'b00:   store_lane = {24'b0, wdata_q[7:0]};
      2'b01:   store_lane = {16'b0, wdata_q[15:0]};
      default: store_lane = wdata_q;
    endcase
  end

  always_comb begin
    load_ext = data_q;
    case (funct3_q)
      3'b000:  load_ext = {{24{data_q[7]}}, data_q[7:0]};
      3'b001:  load_ext = {{16{data_q[15]}}, data_q[15:0]};
      3'b100:  load_ext = {24'b0, data_q[7:0]};
      3'b101:  load_ext = {16'b0, data_q[15:0]};
      default: load_ext = data_q;
    endcase
    if (we_q || err_q) load_ext = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Bus and response outputs decode straight from the state register so a
  // reset mid-access drops dram_wen without waiting for a clock.
  always_comb begin
    state_next  = state;
    perip_addr  = '0;
    perip_wdata = '0;
    perip_mask  = 2'b10;
    dram_wen    = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    case (state)
      IDLE: state_next = IDLE;
      ACCESS: begin
        perip_addr  = addr_q;
        perip_mask  = funct3_q[1:0];
        perip_wdata = store_lane;
        dram_wen    = we_q;
        state_next  = RESP;
      end
      BYTE: begin
        perip_addr  = addr_q + ADDR_W'(idx_q);
        perip_mask  = 2'b00;
        perip_wdata = {24'b0, 8'(wdata_q >> {idx_q, 3'b000})};
        dram_wen    = we_q;
        if (idx_q == last_q) state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = load_ext;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (accept) state_next = err_d ? RESP : (aligned ? ACCESS : BYTE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      last_q   <= '0;
      data_q   <= '0;
    end else if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[ADDR_W-1:0];
      wdata_q  <= req_wdata;
      err_q    <= err_d;
      idx_q    <= '0;
      last_q   <= req_funct3[1] ? 2'd3 : 2'd1;
      data_q   <= '0;
    end else if (state == ACCESS) begin
      data_q <= perip_rdata;
    end else if (state == BYTE) begin
      data_q[8*idx_q +: 8] <= perip_rdata[7:0];
      idx_q                <= idx_q + 2'd1;
    end
  end

endmodule
